hamming_dec_stream: RTL and testbench

//  Receive-side SECDED decoder, the inverse of the ALU parity/pack ops.
//  - Accepts one 16-bit Hamming(16,11) codeword as two bytes, LSW then MSW.
//  - Computes syndrome and overall parity; corrects single-bit errors, flags double-bit errors.
//  - Returns 11-bit data over a valid/ready handshake; sits between data memory and the register file.

---
 rtl/hamming_dec_stream.sv | 118 +++++++++++
 tb/tb_hamming_dec_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec_stream.sv
// Streaming Hamming(16,11) SECDED decoder: two input bytes (LSW, MSW) in, 11-bit data plus status out.
// Optional saturating error counters are built when HAMMING_DEC_ERR_CNT_EN is defined.
module hamming_dec_stream #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_byte,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [10:0]      out_data,
   output logic [1:0]       out_stat,
   output logic [3:0]       out_pos,
   output logic [CNT_W-1:0] cnt_sgl,
   output logic [CNT_W-1:0] cnt_dbl
);

   typedef enum logic [1:0] {S_LSW, S_MSW, S_CALC, S_OUT} state_t;

   state_t      state, state_nxt;
   logic        live;
   logic [7:0]  lsw_q, msw_q;
   logic [15:0] word, fixed;
   logic [3:0]  syn;
   logic        par;
   logic [10:0] data_c;
   logic [1:0]  stat_c;
   logic [3:0]  pos_c;
   logic        in_fire, out_fire;

   // Syndrome is the XOR of the indices of all set bits.
   always_comb begin
      word = {msw_q, lsw_q};
      syn  = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (word[i]) syn = syn ^ 4'(i);
      end
      par    = ^word;
      fixed  = word;
      stat_c = 2'b00;
      pos_c  = '0;
      if (par) begin
         stat_c = 2'b01;
         pos_c  = syn;
         if (syn != 4'd0) fixed[syn] = ~word[syn];
      end else if (syn != 4'd0) begin
         stat_c = 2'b10;
         pos_c  = syn;
      end
      data_c = {fixed[15:9], fixed[7:5], fixed[3]};
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_LSW: begin
            in_ready = live;
            if (in_valid && live) state_nxt = S_MSW;
         end
         S_MSW: begin
            in_ready = live;
            if (in_valid && live) state_nxt = S_CALC;
         end
         S_CALC: state_nxt = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_LSW;
         end
         default: state_nxt = S_LSW;
      endcase
   end

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // live holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_LSW;
         live     <= 1'b0;
         lsw_q    <= '0;
         msw_q    <= '0;
         out_data <= '0;
         out_stat <= '0;
         out_pos  <= '0;
      end else begin
         state <= state_nxt;
         live  <= 1'b1;
         if (in_fire && state == S_LSW) lsw_q <= in_byte;
         if (in_fire && state == S_MSW) msw_q <= in_byte;
         if (state == S_CALC) begin
            out_data <= data_c;
            out_stat <= stat_c;
            out_pos  <= pos_c;
         end
      end
   end

`ifdef HAMMING_DEC_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_sgl <= '0;
         cnt_dbl <= '0;
      end else if (out_fire) begin
         if (out_stat == 2'b01 && cnt_sgl != '1) cnt_sgl <= cnt_sgl + CNT_W'(1);
         if (out_stat == 2'b10 && cnt_dbl != '1) cnt_dbl <= cnt_dbl + CNT_W'(1);
      end
   end
`else
   assign cnt_sgl = '0;
   assign cnt_dbl = '0;
`endif

endmodule

// File: tb/tb_hamming_dec_stream.sv
// Self-checking bench for hamming_dec_stream: directed cases plus randomized words
// whose expected results are derived from the injected error pattern.
module tb_hamming_dec_stream;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_byte = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [10:0]      out_data;
   logic [1:0]       out_stat;
   logic [3:0]       out_pos;
   logic [CNT_W-1:0] cnt_sgl, cnt_dbl;

   int unsigned n_chk = 0, n_pass = 0;
   int unsigned m_sgl = 0, m_dbl = 0;

   hamming_dec_stream #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_stat(out_stat), .out_pos(out_pos),
      .cnt_sgl(cnt_sgl), .cnt_dbl(cnt_dbl)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] w = '0;
      logic p;
      for (int unsigned i = 0; i < 11; i++) w[DPOS[i]] = d[i];
      for (int unsigned k = 0; k < 4; k++) begin
         p = 1'b0;
         for (int unsigned j = 1; j < 16; j++)
            if (((j >> k) & 1) == 1) p = p ^ w[j];
         w[1 << k] = p;
      end
      w[0] = ^w;
      return w;
   endfunction

   function automatic logic [10:0] extract(input logic [15:0] w);
      logic [10:0] d;
      for (int unsigned i = 0; i < 11; i++) d[i] = w[DPOS[i]];
      return d;
   endfunction

   function automatic logic [2*CNT_W-1:0] exp_cnt();
`ifdef HAMMING_DEC_ERR_CNT_EN
      return {CNT_W'(m_sgl), CNT_W'(m_dbl)};
`else
      return '0;
`endif
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int unsigned n = 0;
      in_valid = 1'b1;
      in_byte  = b;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      else @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run_word(input logic [15:0] w, input logic [10:0] ed, input logic [1:0] es,
                           input logic [3:0] ep, input int unsigned hold);
      int unsigned sat = (1 << CNT_W) - 1;
      send_byte(w[7:0]);
      send_byte(w[15:8]);
      check("calc_gap", {out_valid, in_ready}, 2'b00);
      @(posedge clk); #1;
      check("lat_valid", 32'(out_valid), 32'd1);
      check("data", 32'(out_data), 32'(ed));
      check("stat", 32'(out_stat), 32'(es));
      check("pos", 32'(out_pos), 32'(ep));
      for (int unsigned h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_byte  = 8'($urandom);
         @(posedge clk); #1;
         check("hold", {out_valid, in_ready, out_data, out_stat, out_pos},
               {1'b1, 1'b0, ed, es, ep});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (es == 2'b01 && m_sgl < sat) m_sgl++;
      if (es == 2'b10 && m_dbl < sat) m_dbl++;
      check("accept", {out_valid, in_ready}, 2'b01);
      check("counters", 32'({cnt_sgl, cnt_dbl}), 32'(exp_cnt()));
   endtask

   initial begin
      logic [15:0] w;
      logic [10:0] d, ed;
      logic [1:0]  es;
      int unsigned ne, a, b;

      repeat (2) @(posedge clk);
      #1;
      check("rst_state", {in_ready, out_valid, out_data, out_stat, out_pos}, '0);
      check("rst_cnt", 32'({cnt_sgl, cnt_dbl}), 32'd0);
      rst_n = 1'b1;
      check("rst_rel_ready_lo", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("rst_rel_ready_hi", 32'(in_ready), 32'd1);

      run_word(16'hFFFF, 11'h7FF, 2'b00, 4'd0, 0);
      run_word(16'hFFDF, 11'h7FF, 2'b01, 4'd5, 1);
      run_word(16'hFFFE, 11'h7FF, 2'b01, 4'd0, 0);
      run_word(16'hFFD7, 11'h7FC, 2'b10, 4'd6, 5);

      // Reset between LSW and MSW, then a fresh all-zero word.
      send_byte(8'h3C);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_outs", {in_ready, out_valid, out_data, out_stat, out_pos, cnt_sgl, cnt_dbl}, '0);
      m_sgl = 0;
      m_dbl = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_ready_lo", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("midrst_ready_hi", 32'(in_ready), 32'd1);
      run_word(16'h0000, 11'h000, 2'b00, 4'd0, 0);

      for (int t = 0; t < 200; t++) begin
         d  = 11'($urandom);
         w  = encode(d);
         ne = $urandom_range(0, 2);
         a  = $urandom_range(0, 15);
         b  = (a + $urandom_range(1, 15)) % 16;
         if (ne == 0) begin
            run_word(w, d, 2'b00, 4'd0, $urandom_range(0, 3));
         end else if (ne == 1) begin
            w[a] = ~w[a];
            run_word(w, d, 2'b01, 4'(a), $urandom_range(0, 3));
         end else begin
            w[a] = ~w[a];
            w[b] = ~w[b];
            ed = extract(w);
            es = 2'b10;
            run_word(w, ed, es, 4'(a ^ b), $urandom_range(0, 3));
         end
      end

`ifdef HAMMING_DEC_ERR_CNT_EN
      for (int t = 0; t < 300; t++) begin
         d = 11'($urandom);
         w = encode(d);
         a = $urandom_range(0, 15);
         w[a] = ~w[a];
         run_word(w, d, 2'b01, 4'(a), 0);
      end
      check("cnt_sgl_sat", 32'(cnt_sgl), 32'd255);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
